// File: rtl/case_conv_pkg.sv
// ============================================================================
// case_conv_pkg : shared types and ASCII constants for the case converter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package case_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_UPPER = 2'd1,
    MODE_LOWER = 2'd2
  } mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_Z     = 8'h5A;
  localparam logic [7:0] CH_LA    = 8'h61;
  localparam logic [7:0] CH_LZ    = 8'h7A;
  localparam int         CASE_BIT = 5;

endpackage

`default_nettype wire

// File: rtl/case_conv_core.sv
// ============================================================================
// case_conv_core : stateless ASCII upper/lower/pass converter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module case_conv_core
  import case_conv_pkg::*;
(
  input  logic [7:0] data_in,
  input  logic [1:0] mode,
  output logic [7:0] data_out,
  output logic       changed
);

  always_comb begin
    data_out = data_in;
    if (mode == MODE_UPPER && data_in >= CH_LA && data_in <= CH_LZ) begin
      data_out[CASE_BIT] = 1'b0;
    end else if (mode == MODE_LOWER && data_in >= CH_A && data_in <= CH_Z) begin
      data_out[CASE_BIT] = 1'b1;
    end
  end

  assign changed = (data_out != data_in);

endmodule

`default_nettype wire

// File: rtl/case_conv_arbiter.sv
// ============================================================================
// case_conv_arbiter : two-requester packet round-robin over one case converter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module case_conv_arbiter
  import case_conv_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_data,
  input  logic [1:0]       req_last,
  input  logic [3:0]       req_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_src,
  output logic [CNT_W-1:0] conv_count,
  output logic             busy
);

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic [1:0] mode_lk, mode_lk_nxt;
  logic       rr_ptr, rr_nxt;

  logic       load;
  logic       sel;
  logic       accept;
  logic [1:0] cur_mode;
  logic [7:0] cur_data;
  logic       cur_last;
  logic [7:0] conv_data;
  logic       conv_changed;

  assign load = !out_valid || out_ready;

  // In IDLE the pointer side wins if it is asking, otherwise the other side.
  assign sel = (state == S_GRANT) ? owner
             : (req_valid[rr_ptr] ? rr_ptr : ~rr_ptr);

  assign req_ready = load ? (2'b01 << sel) : 2'b00;
  assign accept    = load && req_valid[sel];
  assign cur_data  = req_data[{sel, 3'b000} +: 8];
  assign cur_last  = req_last[sel];
  assign cur_mode  = (state == S_GRANT) ? mode_lk : req_mode[{sel, 1'b0} +: 2];

  case_conv_core u_core (
    .data_in  (cur_data),
    .mode     (cur_mode),
    .data_out (conv_data),
    .changed  (conv_changed)
  );

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    mode_lk_nxt = mode_lk;
    rr_nxt      = rr_ptr;
    if (accept) begin
      if (cur_last) begin
        state_nxt = S_IDLE;
        rr_nxt    = ~sel;
      end else if (state == S_IDLE) begin
        state_nxt   = S_GRANT;
        owner_nxt   = sel;
        mode_lk_nxt = cur_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      mode_lk <= MODE_PASS;
      rr_ptr  <= (RR_INIT != 0);
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      mode_lk <= mode_lk_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      out_src    <= 1'b0;
      conv_count <= '0;
    end else begin
      if (load) begin
        out_valid <= accept;
        if (accept) begin
          out_data <= conv_data;
          out_last <= cur_last;
          out_src  <= sel;
        end
      end
      if (accept && conv_changed && (conv_count != {CNT_W{1'b1}})) begin
        conv_count <= conv_count + 1'b1;
      end
    end
  end

  assign busy = (state == S_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_case_conv_arbiter.sv
// ============================================================================
// tb_case_conv_arbiter : directed stimulus with a cycle-level reference model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_case_conv_arbiter;

  typedef byte unsigned bq_t[$];

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [3:0]  req_mode;
  logic        out_ready;

  logic [1:0]  req_ready_a, req_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [7:0]  out_data_a, out_data_b;
  logic        out_last_a, out_last_b;
  logic        out_src_a, out_src_b;
  logic [15:0] conv_count_a;
  logic [3:0]  conv_count_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  logic [9:0] cap_q[$];
  logic [9:0] exp_q[$];

  case_conv_arbiter #(.CNT_W(16), .RR_INIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_data(req_data), .req_last(req_last), .req_mode(req_mode),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .out_src(out_src_a), .conv_count(conv_count_a),
    .busy(busy_a)
  );

  case_conv_arbiter #(.CNT_W(4), .RR_INIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_data(req_data), .req_last(req_last), .req_mode(req_mode),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .out_src(out_src_b), .conv_count(conv_count_b),
    .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] conv(input logic [7:0] d, input logic [1:0] m);
    if (m == 2'd1 && d >= "a" && d <= "z") return d - 8'd32;
    if (m == 2'd2 && d >= "A" && d <= "Z") return d + 8'd32;
    return d;
  endfunction

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference model: state after each rising edge, evaluated at the falling edge.
  bit         m_valid, m_last, m_src, m_busy, m_owner, m_rr;
  logic [7:0] m_data;
  logic [1:0] m_mode;
  int         m_cnt;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 0; m_last = 0; m_src = 0; m_busy = 0; m_owner = 0; m_rr = 0;
        m_data = 8'h00; m_mode = 2'd0; m_cnt = 0;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", out_data_a, 0);
        chk("rst_out_last", out_last_a, 0);
        chk("rst_out_src", out_src_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_count", conv_count_a, 0);
        chk("rst_count_b", conv_count_b, 0);
      end else begin
        bit         load, sel, acc;
        logic [1:0] exp_rdy, md;
        logic [7:0] d, c;
        int         s;
        chk("out_valid", out_valid_a, m_valid);
        chk("out_valid_b", out_valid_b, m_valid);
        if (m_valid) begin
          chk("out_data", out_data_a, m_data);
          chk("out_data_b", out_data_b, m_data);
          chk("out_last", out_last_a, m_last);
          chk("out_src", out_src_a, m_src);
        end
        chk("busy", busy_a, m_busy);
        chk("conv_count", conv_count_a, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("conv_count_b", conv_count_b, (m_cnt > 15) ? 15 : m_cnt);

        load    = !m_valid || out_ready;
        sel     = m_busy ? m_owner : (req_valid[m_rr] ? m_rr : !m_rr);
        exp_rdy = load ? (2'b01 << sel) : 2'b00;
        chk("req_ready", req_ready_a & req_valid, exp_rdy & req_valid);
        acc = load && req_valid[sel];
        s   = int'(sel);

        if (out_valid_a && out_ready) cap_q.push_back({out_src_a, out_last_a, out_data_a});

        if (load) begin
          if (acc) begin
            md = m_busy ? m_mode : req_mode[s*2 +: 2];
            d  = req_data[s*8 +: 8];
            c  = conv(d, md);
            if (c != d) m_cnt++;
            m_valid = 1; m_data = c; m_last = req_last[s]; m_src = sel;
            if (req_last[s]) begin
              m_busy = 0;
              m_rr   = !sel;
            end else if (!m_busy) begin
              m_busy = 1; m_owner = sel; m_mode = md;
            end
          end else begin
            m_valid = 0;
          end
        end
      end
    end
  end

  // Drives one packet on a side; gives up quietly when reset hits mid-packet.
  task automatic send(input int side, input bq_t b, input logic [1:0] m0, input logic [1:0] mr);
    bit acc;
    int n;
    for (int i = 0; i < b.size(); i++) begin
      req_valid[side]          = 1'b1;
      req_data[side*8 +: 8]    = b[i];
      req_last[side]           = (i == b.size() - 1);
      req_mode[side*2 +: 2]    = (i == 0) ? m0 : mr;
      acc = 0;
      n   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = req_ready_a[side] && rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
          req_valid[side] = 1'b0;
          req_last[side]  = 1'b0;
          return;
        end
        n++;
        if (n > 200) begin
          chk("send_timeout", 0, 1);
          req_valid[side] = 1'b0;
          return;
        end
      end
    end
    req_valid[side] = 1'b0;
    req_last[side]  = 1'b0;
  endtask

  task automatic add_exp(input string s, input bit src);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({src, (i == s.len() - 1), s[i]});
  endtask

  task automatic chk_cap(input string name);
    chk({name, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) chk(name, cap_q[i], exp_q[i]);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_out(input logic [7:0] ch, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid_a && out_data_a == ch) && n < 100);
    if (n >= 100) chk(name, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; req_valid = '0; req_data = '0; req_last = '0; req_mode = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_busy", busy_a, 0);
    chk("init_valid", out_valid_a, 0);

    // Every byte value as an upper-mode single-byte packet.
    for (int v = 0; v < 256; v++) begin
      bq_t q;
      q.delete();
      q.push_back(8'(v));
      send(0, q, 2'd1, 2'd1);
    end
    drain();
    chk("t1_count", conv_count_a, 26);
    chk("t1_count_b_sat", conv_count_b, 15);
    do_reset();

    // Simultaneous requests: r0 wins first, whole packets in order.
    fork
      send(0, to_q("ab"), 2'd1, 2'd1);
      send(1, to_q("CD"), 2'd2, 2'd2);
    join
    drain();
    add_exp("AB", 1'b0);
    add_exp("cd", 1'b1);
    chk_cap("t2_cap");

    // Back-pressure while 'Y' is held in the output stage.
    fork
      send(0, to_q("xyz"), 2'd1, 2'd1);
      begin
        wait_out("X", "t3_wait_x");
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t3_hold_data", out_data_a, "Y");
          chk("t3_hold_ready", req_ready_a[0], 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    add_exp("XYZ", 1'b0);
    chk_cap("t3_cap");

    // Mode lines flip after the first byte; packet keeps the first mode.
    send(0, to_q("abc"), 2'd1, 2'd2);
    drain();
    add_exp("ABC", 1'b0);
    chk_cap("t4_cap");

    // Asynchronous reset while r1 owns a packet and a byte is held.
    out_ready = 1'b0;
    fork
      send(1, to_q("abcdef"), 2'd1, 2'd1);
      begin
        wait_out("A", "t5_wait_a");
        chk("t5_busy_pre", busy_a, 1);
        chk("t5_src_pre", out_src_a, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid_a, 0);
        chk("t5_async_busy", busy_a, 0);
        chk("t5_async_count", conv_count_a, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    out_ready = 1'b1;
    cap_q.delete();
    @(posedge clk);
    #1;
    fork
      send(0, to_q("q"), 2'd0, 2'd0);
      send(1, to_q("r"), 2'd0, 2'd0);
    join
    drain();
    add_exp("q", 1'b0);
    add_exp("r", 1'b1);
    chk_cap("t5_after_reset");

    // Saturation on the narrow counter.
    do_reset();
    send(0, to_q("aaaaaaaaaaaaaaaaaaaa"), 2'd1, 2'd1);
    drain();
    chk("t6_count_b", conv_count_b, 15);
    chk("t6_count_a", conv_count_a, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
